// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the nibble width, the default digit count, width helpers for the
// scan/blink counters and the load FSM state type.
package sseg_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int DEFAULT_DIGITS = 4;

    // Counter width for a counter running 0..n-1, never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_width(input int digits);
        return cnt_width(digits);
    endfunction

    function automatic int prescaler_width(input int div);
        return cnt_width(div);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } load_state_t;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Bundle between user logic and the scan controller / decoder side.
//   master: user side; drives load/value/blank_lz/blink_mask, observes the rest
//   slave : the scan controller
// Signals:
//   load, value        value update request (value nibble i is digit i)
//   blank_lz           leading-zero blanking enable (level)
//   blink_mask         per-digit blink enable (level)
//   busy, load_ack     load status
//   dig_sel_n          one-hot-low digit select
//   dec_en, dec_data   decoder enable / nibble
//   frame_tick         one-cycle pulse after each frame wrap
//   state_dbg          load FSM state, for observation only
//
// Load handshake: load is a single-cycle request that is always accepted and
// never back-pressured. busy is high while an accepted value waits for the
// next frame boundary; load_ack pulses for one cycle when a value becomes the
// displayed one. A later load before the boundary replaces the waiting value.
interface sseg_scan_ctrl_if #(
    parameter int DIGITS = sseg_pkg::DEFAULT_DIGITS
);
    import sseg_pkg::*;

    logic                         load;
    logic [NIBBLE_W*DIGITS-1:0]   value;
    logic                         blank_lz;
    logic [DIGITS-1:0]            blink_mask;
    logic                         busy;
    logic                         load_ack;
    logic [DIGITS-1:0]            dig_sel_n;
    logic                         dec_en;
    logic [NIBBLE_W-1:0]          dec_data;
    logic                         frame_tick;
    load_state_t                  state_dbg;

    modport master (
        output load, value, blank_lz, blink_mask,
        input  busy, load_ack, dig_sel_n, dec_en, dec_data, frame_tick, state_dbg
    );

    modport slave (
        input  load, value, blank_lz, blink_mask,
        output busy, load_ack, dig_sel_n, dec_en, dec_data, frame_tick, state_dbg
    );

endinterface

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every DIV clocks.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   tick        high while the prescaler sits at DIV-1
module sseg_tick_gen
    import sseg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = prescaler_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan sequencer for a shared seven-segment decoder.
// Time-multiplexes DIGITS nibbles onto one decoder, with leading-zero
// blanking, per-digit blink and value updates that only land on a frame
// boundary so a frame never shows a mix of old and new digits.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sseg_scan_ctrl_if slave modport (see interface header)
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS       = DEFAULT_DIGITS,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    sseg_scan_ctrl_if.slave    bus
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int BLK_W = cnt_width(BLINK_FRAMES);
    localparam int VAL_W = NIBBLE_W * DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic                  slot_tick;
    logic                  boundary;
    logic [IDX_W-1:0]      idx;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [VAL_W-1:0]      active;
    logic [VAL_W-1:0]      pending;
    load_state_t           state;
    logic                  busy_q;
    logic                  load_ack_q;
    logic                  upper_nonzero;
    logic                  lz_blank;
    logic                  blink_dark;
    logic [NIBBLE_W-1:0]   cur_nibble;

    sseg_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (slot_tick)
    );

    assign boundary = slot_tick && (idx == IDX_LAST);

    // Digit idx is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx)) && (active[NIBBLE_W*i +: NIBBLE_W] != '0)) begin
                upper_nonzero = 1'b1;
            end
        end
    end

    assign lz_blank   = bus.blank_lz && (idx != '0) && !upper_nonzero;
    assign blink_dark = bus.blink_mask[idx] && blink_phase;
    assign cur_nibble = active[NIBBLE_W*idx +: NIBBLE_W];

    // Scan position and blink timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (slot_tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (boundary) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Registered display outputs: one cycle behind idx/active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dig_sel_n  <= '1;
            bus.dec_en     <= 1'b0;
            bus.dec_data   <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.dig_sel_n  <= ~(DIGITS'(1) << idx);
            bus.dec_en     <= ~(lz_blank || blink_dark);
            bus.dec_data   <= cur_nibble;
            bus.frame_tick <= boundary;
        end
    end

    // Load FSM. A load on the boundary cycle itself bypasses pending and
    // takes priority over any older waiting value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= '0;
            pending    <= '0;
            busy_q     <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        if (boundary) begin
                            active     <= bus.value;
                            load_ack_q <= 1'b1;
                        end else begin
                            pending <= bus.value;
                            state   <= PEND;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (boundary) begin
                        active     <= bus.load ? bus.value : pending;
                        load_ack_q <= 1'b1;
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                    end else if (bus.load) begin
                        pending <= bus.value;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.load_ack  = load_ack_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_sseg_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    sseg_scan_ctrl_if #(.DIGITS(ND)) bus ();

    sseg_scan_ctrl #(
        .DIGITS       (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edge k (1-based since reset release) displays digit ((k-1)/SD)%ND of
    // the value active before that edge; edge k is a frame boundary when
    // k is a multiple of FRAME; blink phase is (boundaries so far / BF) odd.
    int          m_edges;
    logic [15:0] m_active;
    logic        m_pend;
    logic [15:0] m_pend_v;
    logic [3:0]  exp_sel  = 4'hF;
    logic        exp_en   = 1'b0;
    logic [3:0]  exp_data = 4'h0;
    logic        exp_busy = 1'b0;
    logic        exp_ack  = 1'b0;
    logic        exp_tick = 1'b0;

    int          mk, pidx, nb;
    logic        bnd, phase, lz, bl;
    logic [15:0] shifted;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges  <= 0;
            m_active <= '0;
            m_pend   <= 1'b0;
            m_pend_v <= '0;
            exp_sel  <= 4'hF;
            exp_en   <= 1'b0;
            exp_data <= 4'h0;
            exp_busy <= 1'b0;
            exp_ack  <= 1'b0;
            exp_tick <= 1'b0;
        end else begin
            mk      = m_edges + 1;
            pidx    = ((mk - 1) / SD) % ND;
            bnd     = (mk % FRAME) == 0;
            nb      = (mk - 1) / FRAME;
            phase   = ((nb / BF) % 2) == 1;
            shifted = m_active >> (4 * pidx);
            lz      = bus.blank_lz && (pidx != 0) && (shifted == 16'h0);
            bl      = bus.blink_mask[pidx] && phase;
            m_edges  <= mk;
            exp_sel  <= ~(4'(1) << pidx);
            exp_data <= shifted[3:0];
            exp_en   <= !(lz || bl);
            exp_tick <= bnd;
            if (bnd) begin
                exp_ack  <= bus.load || m_pend;
                if (bus.load) m_active <= bus.value;
                else if (m_pend) m_active <= m_pend_v;
                m_pend   <= 1'b0;
                exp_busy <= 1'b0;
            end else begin
                exp_ack <= 1'b0;
                if (bus.load) begin
                    m_pend   <= 1'b1;
                    m_pend_v <= bus.value;
                    exp_busy <= 1'b1;
                end else begin
                    exp_busy <= m_pend;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("dig_sel_n",  bus.dig_sel_n,  exp_sel);
        check("dec_en",     bus.dec_en,     exp_en);
        check("dec_data",   bus.dec_data,   exp_data);
        check("busy",       bus.busy,       exp_busy);
        check("load_ack",   bus.load_ack,   exp_ack);
        check("frame_tick", bus.frame_tick, exp_tick);
    end

    // ---------------- driver tasks ----------------
    // Return at the negedge before the edge whose index mod FRAME is r.
    task automatic wait_pre(input int r);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            if (((m_edges + 1) % FRAME) == r) hit = 1'b1;
        end
        check("wait_pre", 32'(hit), 32'd1);
    endtask

    // Return at the negedge just after the edge whose index mod FRAME is r.
    task automatic at_mod(input int r);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            if ((m_edges % FRAME) == r) hit = 1'b1;
        end
        check("at_mod", 32'(hit), 32'd1);
    endtask

    task automatic do_load(input int r, input logic [15:0] v);
        wait_pre(r);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] pat;
    int         acks;

    initial begin
        rst_n          = 1'b0;
        bus.load       = 1'b0;
        bus.value      = '0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        n_chk = 0;
        n_err = 0;

        repeat (3) @(negedge clk);
        check("rst_sel", bus.dig_sel_n, 32'hF);
        check("rst_en",  bus.dec_en,    32'h0);
        rst_n = 1'b1;

        // idle scanning
        @(negedge clk);
        check("first_sel",  bus.dig_sel_n, 32'hE);
        check("first_en",   bus.dec_en,    32'h1);
        check("first_data", bus.dec_data,  32'h0);
        repeat (4) @(negedge clk);
        check("slot1_sel", bus.dig_sel_n, 32'hD);
        at_mod(0);
        check("frame_tick_16", bus.frame_tick, 32'h1);
        check("sel_digit3",    bus.dig_sel_n,  32'h7);

        // mid-frame load
        do_load(5, 16'h1234);
        check("busy_after_load", bus.busy, 32'h1);
        at_mod(0);
        check("ack_at_boundary",  bus.load_ack, 32'h1);
        check("busy_cleared",     bus.busy,     32'h0);
        at_mod(1);
        check("new_digit0", bus.dec_data, 32'h4);
        at_mod(5);
        check("new_digit1", bus.dec_data, 32'h3);
        at_mod(13);
        check("new_digit3", bus.dec_data, 32'h1);

        // leading-zero blanking
        bus.blank_lz = 1'b1;
        do_load(3, 16'h0050);
        at_mod(1);  check("lz50_d0", bus.dec_en, 32'h1);
        at_mod(5);  check("lz50_d1", bus.dec_en, 32'h1);
        check("lz50_d1_data", bus.dec_data, 32'h5);
        at_mod(9);  check("lz50_d2", bus.dec_en, 32'h0);
        at_mod(13); check("lz50_d3", bus.dec_en, 32'h0);
        do_load(3, 16'h0000);
        at_mod(1);  check("lz0_d0", bus.dec_en, 32'h1);
        at_mod(5);  check("lz0_d1", bus.dec_en, 32'h0);

        // blink on digit 1
        bus.blank_lz   = 1'b0;
        bus.blink_mask = 4'b0010;
        for (int f = 0; f < 4; f++) begin
            at_mod(5);
            pat[f] = bus.dec_en;
        end
        check("blink_dark_frames", 32'($countones(~pat)), 32'd2);
        check("blink_period",      32'(pat[0] != pat[2]), 32'd1);
        bus.blink_mask = '0;

        // two loads in one frame: last wins, single ack
        do_load(3, 16'hAAAA);
        do_load(7, 16'hBBBB);
        acks = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (bus.load_ack) acks++;
        end
        check("single_ack", 32'(acks), 32'd1);
        at_mod(1);
        check("last_wins", bus.dec_data, 32'hB);

        // load on the boundary cycle
        wait_pre(0);
        bus.load  = 1'b1;
        bus.value = 16'hCCCC;
        @(negedge clk);
        bus.load  = 1'b0;
        check("bnd_ack",  bus.load_ack, 32'h1);
        check("bnd_busy", bus.busy,     32'h0);
        @(negedge clk);
        check("bnd_data", bus.dec_data, 32'hC);

        // reset while a value is pending, idx 2 on display
        do_load(2, 16'hDDDD);
        at_mod(10);
        check("pend_busy", bus.busy,      32'h1);
        check("pend_sel",  bus.dig_sel_n, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel",  bus.dig_sel_n,  32'hF);
        check("arst_en",   bus.dec_en,     32'h0);
        check("arst_data", bus.dec_data,   32'h0);
        check("arst_busy", bus.busy,       32'h0);
        check("arst_ack",  bus.load_ack,   32'h0);
        check("arst_tick", bus.frame_tick, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_sel",  bus.dig_sel_n, 32'hE);
        check("post_rst_data", bus.dec_data,  32'h0);
        repeat (2 * FRAME + 4) @(negedge clk);
        check("pend_lost_busy", bus.busy, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Sequencer for a shared seven-segment decoder: time-multiplexes DIGITS hex nibbles onto one decoder and drives per-digit active-low select lines. The decoder takes en, 4-bit data and an 8-bit active-low led output.
Adds leading-zero blanking, per-digit blink and tear-free value update: a new value takes effect only at a frame boundary.
Sits between user logic (counters, debug registers) and the decoder/LED pins.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (>=2)
BLINK_FRAMES, 100, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle request to update displayed value
value  in  4*DIGITS  new value; nibble i is digit i; digit 0 is least significant
blank_lz  in  1  enable leading-zero blanking (level, sampled every cycle)
blink_mask  in  DIGITS  1 = digit blinks (level)
busy  out  1  a loaded value is pending, not yet displayed
load_ack  out  1  one-cycle pulse when a value becomes active
dig_sel_n  out  DIGITS  one-hot-low digit select
dec_en  out  1  decoder enable; 0 blanks the digit
dec_data  out  4  nibble to the decoder
frame_tick  out  1  one-cycle pulse at each frame wrap

Behaviour:
Reset (async, rst_n=0):
- Outputs: dig_sel_n all 1; dec_en=0; dec_data=0; busy=0; load_ack=0; frame_tick=0.
- Internal: active=0, pending=0, prescaler=0, idx=0, blink_cnt=0, blink_phase=0.

Scan timing:
- Prescaler counts 0..SCAN_DIV-1. slot_tick is asserted when prescaler==SCAN_DIV-1.
- On slot_tick: idx increments, wrapping DIGITS-1 -> 0.
- boundary = slot_tick and idx==DIGITS-1.
- frame_tick is registered and pulses in the cycle after boundary.

Display outputs:
- All display outputs are registered. They reflect the current idx and active value with 1-cycle latency.
- dig_sel_n = ~(1<<idx). From the first clock after reset release, digit 0 is selected.
- dec_data = active[4*idx +: 4].
- blanked(idx) = (blank_lz and idx!=0 and active nibbles idx..DIGITS-1 all zero) or (blink_mask[idx] and blink_phase).
- Digit 0 is never leading-zero blanked.
- dec_en = ~blanked(idx).

Blink:
- blink_cnt counts boundaries 0..BLINK_FRAMES-1.
- blink_phase toggles on the boundary where blink_cnt==BLINK_FRAMES-1; blink_cnt then wraps to 0.
- blink_phase=1 means blinking digits are dark.

Load FSM (states IDLE, PEND; busy=1 exactly in PEND):
- IDLE, load=1, no boundary: pending<=value; go to PEND.
- IDLE or PEND, load=1 on a boundary cycle: active<=value directly; load_ack=1 next cycle; go to IDLE. Any older pending value is discarded.
- PEND, load=1, no boundary: pending<=value (last write wins); stay in PEND; no ack.
- PEND, boundary, load=0: active<=pending; load_ack=1 next cycle; go to IDLE.
- IDLE, boundary, load=0: no change.
- active changes only at boundary, so a frame never mixes old and new nibbles.
- rst_n asserted mid-frame or in PEND: pending is discarded; outputs return to reset values immediately.

Width rules:
- idx width = clog2(DIGITS). Prescaler width = clog2(SCAN_DIV). No arithmetic overflow is possible.

Decomposition:
- Package sseg_pkg: NIBBLE_W=4; default DIGITS; localparam functions for idx and prescaler widths; load FSM state enum {IDLE, PEND}.
- Sub-module: sseg_tick_gen (prescaler + slot_tick strobe), reusable for other LED/scan timers.
- The decoder stays a separate instance outside this block, fed by dec_en/dec_data.

Test Plan (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2):
- Reset release, no load -> dig_sel_n cycles 1110,1101,1011,0111 every 4 clk; dec_data=0; digit 0 dec_en=1; frame_tick every 16 clk.
- load value=16'h1234 mid-frame -> busy=1 until boundary; load_ack 1 cycle after boundary; next frame dec_data 4,3,2,1; busy=0.
- blank_lz=1, active 16'h0050 -> dec_en per idx 0..3 = 1,1,0,0. Active 16'h0000 -> 1,0,0,0.
- blink_mask=4'b0010 -> digit 1 dec_en alternates: 2 frames lit, 2 frames dark. Other digits are unaffected.
- Two loads (16'hAAAA then 16'hBBBB) in one frame -> only BBBB displayed, single load_ack. Load on the boundary cycle -> applied immediately, ack next cycle, busy stays 0.
- rst_n pulse low while busy=1 with idx=2 -> all outputs reset immediately. Pending value is lost; display shows 0 after release.
